// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two cache refill requesters, the shared memory port
// and the arbiter. The arbiter takes the slave view; requesters and memory take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_BITS = 10,
    parameter int LINE_BITS = 128
);
    logic                 ic_req;
    logic [ADDR_BITS-1:0] ic_addr;
    logic [LINE_BITS-1:0] ic_rdata;
    logic                 ic_valid;

    logic                 dc_req;
    logic                 dc_we;
    logic [ADDR_BITS-1:0] dc_addr;
    logic [LINE_BITS-1:0] dc_wdata;
    logic [LINE_BITS-1:0] dc_rdata;
    logic                 dc_valid;

    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [LINE_BITS-1:0] mem_wdata;
    logic [LINE_BITS-1:0] mem_rdata;
    logic                 mem_ack;

    logic [1:0]           owner;
    logic                 timeout_err;

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        input  mem_rdata, mem_ack,
        output ic_rdata, ic_valid,
        output dc_rdata, dc_valid,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output owner, timeout_err
    );

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wdata,
        output mem_rdata, mem_ack,
        input  ic_rdata, ic_valid,
        input  dc_rdata, dc_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  owner, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache refill
// and D-cache refill/writeback paths, one transaction in flight, with a response watchdog.
module mem_port_arbiter #(
    parameter int ADDR_BITS = 10,
    parameter int LINE_BITS = 128,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DRAIN} state_t;

    localparam int                    CNT_BITS = $clog2(TIMEOUT + 2);
    localparam bit                    WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CNT_BITS-1:0]   CNT_LAST = CNT_BITS'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t               state_reg, state_next;
    logic                 favour_d_reg, favour_d_next;
    logic [CNT_BITS-1:0]  cnt_reg, cnt_next;
    logic                 mem_req_reg, mem_req_next;
    logic                 mem_we_reg, mem_we_next;
    logic [ADDR_BITS-1:0] mem_addr_reg, mem_addr_next;
    logic [LINE_BITS-1:0] mem_wdata_reg, mem_wdata_next;
    logic [LINE_BITS-1:0] ic_rdata_reg, ic_rdata_next;
    logic [LINE_BITS-1:0] dc_rdata_reg, dc_rdata_next;
    logic                 ic_valid_reg, ic_valid_next;
    logic                 dc_valid_reg, dc_valid_next;
    logic                 timeout_err_reg, timeout_err_next;
    logic                 grant_i, grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            favour_d_reg    <= 1'b1;
            cnt_reg         <= '0;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            ic_rdata_reg    <= '0;
            dc_rdata_reg    <= '0;
            ic_valid_reg    <= 1'b0;
            dc_valid_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            favour_d_reg    <= favour_d_next;
            cnt_reg         <= cnt_next;
            mem_req_reg     <= mem_req_next;
            mem_we_reg      <= mem_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            ic_rdata_reg    <= ic_rdata_next;
            dc_rdata_reg    <= dc_rdata_next;
            ic_valid_reg    <= ic_valid_next;
            dc_valid_reg    <= dc_valid_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        favour_d_next    = favour_d_reg;
        cnt_next         = cnt_reg;
        mem_req_next     = mem_req_reg;
        mem_we_next      = mem_we_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        ic_rdata_next    = ic_rdata_reg;
        dc_rdata_next    = dc_rdata_reg;
        ic_valid_next    = 1'b0;
        dc_valid_next    = 1'b0;
        timeout_err_next = timeout_err_reg;
        // I wins when alone, or when both ask and the pointer does not favour D.
        grant_i          = bus.ic_req && (!bus.dc_req || !favour_d_reg);
        grant_d          = bus.dc_req && !grant_i;

        case (state_reg)
            IDLE: begin
                if (grant_i) begin
                    state_next    = BUSY_I;
                    favour_d_next = 1'b1;
                    cnt_next      = '0;
                    mem_req_next  = 1'b1;
                    mem_we_next   = 1'b0;
                    mem_addr_next = bus.ic_addr;
                end else if (grant_d) begin
                    state_next     = BUSY_D;
                    favour_d_next  = 1'b0;
                    cnt_next       = '0;
                    mem_req_next   = 1'b1;
                    mem_we_next    = bus.dc_we;
                    mem_addr_next  = bus.dc_addr;
                    mem_wdata_next = bus.dc_wdata;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack on the same cycle the watchdog expires still completes normally.
                if (bus.mem_ack) begin
                    state_next   = DRAIN;
                    mem_req_next = 1'b0;
                    if (state_reg == BUSY_I) begin
                        ic_valid_next = 1'b1;
                        ic_rdata_next = bus.mem_rdata;
                    end else begin
                        dc_valid_next = 1'b1;
                        if (!mem_we_reg) begin
                            dc_rdata_next = bus.mem_rdata;
                        end
                    end
                end else if (WDOG_EN && (cnt_reg == CNT_LAST)) begin
                    state_next       = DRAIN;
                    mem_req_next     = 1'b0;
                    timeout_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.owner       = (state_reg == BUSY_I) ? 2'b01 :
                             (state_reg == BUSY_D) ? 2'b10 : 2'b00;
    assign bus.mem_req     = mem_req_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_wdata   = mem_wdata_reg;
    assign bus.ic_rdata    = ic_rdata_reg;
    assign bus.dc_rdata    = dc_rdata_reg;
    assign bus.ic_valid    = ic_valid_reg;
    assign bus.dc_valid    = dc_valid_reg;
    assign bus.timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single requesters, contention, input stability,
// watchdog expiry (TIMEOUT = 4) and reset in the middle of a transaction.
module tb_mem_port_arbiter;
    localparam int AB = 10;
    localparam int LB = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   ic_seen  = 0;
    int   dc_seen  = 0;
    int   ic_exp   = 0;
    int   dc_exp   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_BITS(AB), .LINE_BITS(LB)) bus ();

    mem_port_arbiter #(.ADDR_BITS(AB), .LINE_BITS(LB), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Count every cycle a valid is high, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.ic_valid === 1'b1) ic_seen++;
        if (bus.dc_valid === 1'b1) dc_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [LB-1:0] a5_line;
        logic [LB-1:0] wr_line;
        logic [LB-1:0] pat;
        logic [1:0]    exp_owner;

        a5_line = {16{8'hA5}};
        wr_line = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

        bus.ic_req = 1'b0; bus.ic_addr = '0;
        bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0; bus.dc_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_mem_req", LB'(bus.mem_req), '0);
        chk("rst_mem_we", LB'(bus.mem_we), '0);
        chk("rst_ic_valid", LB'(bus.ic_valid), '0);
        chk("rst_dc_valid", LB'(bus.dc_valid), '0);
        chk("rst_timeout_err", LB'(bus.timeout_err), '0);
        chk("rst_owner", LB'(bus.owner), '0);
        chk("rst_mem_addr", LB'(bus.mem_addr), '0);
        chk("rst_mem_wdata", bus.mem_wdata, '0);
        chk("rst_ic_rdata", bus.ic_rdata, '0);
        chk("rst_dc_rdata", bus.dc_rdata, '0);
        rst = 1'b0;

        // I-only read, ack in the third cycle after mem_req rises
        bus.ic_req = 1'b1; bus.ic_addr = 10'h005;
        tick();
        chk("i_grant_req", LB'(bus.mem_req), 1);
        chk("i_grant_owner", LB'(bus.owner), 2'b01);
        chk("i_grant_addr", LB'(bus.mem_addr), 10'h005);
        chk("i_grant_we", LB'(bus.mem_we), 0);
        tick(); tick(); tick();
        chk("i_busy_req", LB'(bus.mem_req), 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = a5_line;
        tick();
        bus.mem_ack = 1'b0; bus.ic_req = 1'b0; bus.mem_rdata = '0;
        chk("i_ack_valid", LB'(bus.ic_valid), 1);
        chk("i_ack_rdata", bus.ic_rdata, a5_line);
        chk("i_ack_req", LB'(bus.mem_req), 0);
        chk("i_drain_owner", LB'(bus.owner), 0);
        chk("i_no_dc_valid", LB'(bus.dc_valid), 0);
        chk("i_no_timeout", LB'(bus.timeout_err), 0);
        tick();
        ic_exp++;
        chk("i_valid_off", LB'(bus.ic_valid), 0);
        chk("i_ic_count", LB'(ic_seen), LB'(ic_exp));
        chk("i_dc_count", LB'(dc_seen), LB'(dc_exp));

        // D-only write, ack one cycle after mem_req rises
        bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 10'h3FF; bus.dc_wdata = wr_line;
        tick();
        chk("d_grant_owner", LB'(bus.owner), 2'b10);
        chk("d_grant_we", LB'(bus.mem_we), 1);
        chk("d_grant_addr", LB'(bus.mem_addr), 10'h3FF);
        chk("d_grant_wdata", bus.mem_wdata, wr_line);
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = {4{32'hDEAD_BEEF}};
        tick();
        bus.mem_ack = 1'b0; bus.dc_req = 1'b0; bus.mem_rdata = '0;
        chk("d_ack_valid", LB'(bus.dc_valid), 1);
        chk("d_write_rdata_kept", bus.dc_rdata, '0);
        chk("d_ack_req", LB'(bus.mem_req), 0);
        tick();
        dc_exp++;
        chk("d_valid_off", LB'(bus.dc_valid), 0);
        chk("d_dc_count", LB'(dc_seen), LB'(dc_exp));

        // Contention from reset: expect D, I, D, I with one DRAIN between grants
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ic_req = 1'b1; bus.ic_addr = 10'h011;
        bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 10'h022;
        for (int k = 0; k < 4; k++) begin
            exp_owner = (k % 2 == 0) ? 2'b10 : 2'b01;
            pat = {4{32'hC0DE_0000 | 32'(k + 1)}};
            tick();
            chk("rr_owner", LB'(bus.owner), LB'(exp_owner));
            chk("rr_addr", LB'(bus.mem_addr), (exp_owner == 2'b10) ? LB'(10'h022) : LB'(10'h011));
            tick(); tick();
            bus.mem_ack = 1'b1; bus.mem_rdata = pat;
            tick();
            bus.mem_ack = 1'b0; bus.mem_rdata = '0;
            if (k == 3) begin
                bus.ic_req = 1'b0; bus.dc_req = 1'b0;
            end
            chk("rr_ic_valid", LB'(bus.ic_valid), LB'(exp_owner == 2'b01));
            chk("rr_dc_valid", LB'(bus.dc_valid), LB'(exp_owner == 2'b10));
            chk("rr_rdata", (exp_owner == 2'b01) ? bus.ic_rdata : bus.dc_rdata, pat);
            chk("rr_drain_owner", LB'(bus.owner), 0);
            tick();
            chk("rr_idle_owner", LB'(bus.owner), 0);
            if (exp_owner == 2'b01) ic_exp++; else dc_exp++;
        end
        chk("rr_ic_count", LB'(ic_seen), LB'(ic_exp));
        chk("rr_dc_count", LB'(dc_seen), LB'(dc_exp));

        // Stability: address change and dropped request during BUSY_I are ignored
        bus.ic_req = 1'b1; bus.ic_addr = 10'h010;
        tick();
        chk("st_grant_addr", LB'(bus.mem_addr), 10'h010);
        bus.ic_addr = 10'h020; bus.ic_req = 1'b0;
        tick();
        chk("st_addr_held1", LB'(bus.mem_addr), 10'h010);
        tick();
        chk("st_addr_held2", LB'(bus.mem_addr), 10'h010);
        chk("st_req_held", LB'(bus.mem_req), 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = {8{16'h5A5A}};
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        chk("st_valid", LB'(bus.ic_valid), 1);
        chk("st_rdata", bus.ic_rdata, {8{16'h5A5A}});
        tick();
        ic_exp++;
        chk("st_no_regrant", LB'(bus.owner), 0);

        // Watchdog: no ack for 4 busy cycles
        bus.ic_req = 1'b1; bus.ic_addr = 10'h033;
        tick();
        chk("wd_grant_owner", LB'(bus.owner), 2'b01);
        tick(); tick(); tick();
        chk("wd_req_before", LB'(bus.mem_req), 1);
        chk("wd_err_before", LB'(bus.timeout_err), 0);
        tick();
        chk("wd_req_dropped", LB'(bus.mem_req), 0);
        chk("wd_err_set", LB'(bus.timeout_err), 1);
        chk("wd_no_valid", LB'(bus.ic_valid), 0);
        chk("wd_drain_owner", LB'(bus.owner), 0);
        tick(); tick();
        chk("wd_regrant_owner", LB'(bus.owner), 2'b01);
        chk("wd_regrant_req", LB'(bus.mem_req), 1);
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = {4{32'h0BAD_F00D}};
        tick();
        bus.mem_ack = 1'b0; bus.ic_req = 1'b0; bus.mem_rdata = '0;
        chk("wd_retry_valid", LB'(bus.ic_valid), 1);
        chk("wd_retry_rdata", bus.ic_rdata, {4{32'h0BAD_F00D}});
        chk("wd_err_sticky", LB'(bus.timeout_err), 1);
        tick();
        ic_exp++;
        chk("wd_ic_count", LB'(ic_seen), LB'(ic_exp));

        // Reset in the middle of BUSY_D, then a late ack
        bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 10'h044;
        tick();
        chk("rm_grant_owner", LB'(bus.owner), 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.dc_req = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = {4{32'hFEED_FACE}};
        chk("rm_owner", LB'(bus.owner), 0);
        chk("rm_mem_req", LB'(bus.mem_req), 0);
        chk("rm_mem_addr", LB'(bus.mem_addr), 0);
        chk("rm_err_cleared", LB'(bus.timeout_err), 0);
        chk("rm_ic_rdata", bus.ic_rdata, '0);
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        chk("rm_late_ack_valid", LB'(bus.dc_valid), 0);
        chk("rm_late_ack_rdata", bus.dc_rdata, '0);
        chk("rm_late_ack_owner", LB'(bus.owner), 0);
        tick();
        chk("rm_dc_count", LB'(dc_seen), LB'(dc_exp));
        chk("rm_ic_count", LB'(ic_seen), LB'(ic_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
